// File: rtl/field_pack_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : field_pack_pkg
//  Purpose  : Shared widths, pad constant, FSM state type and the bit-placement
//             helpers used by the field packer and its byte selector.
//  Contents : FIELD_W, NUM_FIELDS, OUT_W, NUM_OUT, FRAME_W, PAD_W, PAD_VALUE,
//             CNT_W, SEL_W, state_t, field_lsb(), byte_lsb()
//  Revision : 1.0 - initial release
// ============================================================================
package field_pack_pkg;

    localparam int FIELD_W    = 5;
    localparam int NUM_FIELDS = 6;
    localparam int OUT_W      = 8;
    localparam int NUM_OUT    = 4;
    localparam int FRAME_W    = NUM_OUT * OUT_W;
    localparam int PAD_W      = FRAME_W - NUM_FIELDS * FIELD_W;

    localparam logic [PAD_W-1:0] PAD_VALUE = 2'b11;

    // Counter widths: field count must be able to show 0..NUM_FIELDS-1,
    // byte select must address NUM_OUT bytes.
    localparam int CNT_W = 3;
    localparam int SEL_W = $clog2(NUM_OUT);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    // Field 0 is the most significant field; the pad occupies the bottom
    // PAD_W bits, so field k sits just above the pad plus (NUM_FIELDS-1-k)
    // later fields.
    function automatic int field_lsb(input logic [CNT_W-1:0] k);
        return PAD_W + (NUM_FIELDS - 1 - int'(k)) * FIELD_W;
    endfunction

    // Byte 0 is the most significant byte of the frame.
    function automatic int byte_lsb(input int b);
        return (NUM_OUT - 1 - b) * OUT_W;
    endfunction

endpackage : field_pack_pkg
`default_nettype wire

// File: rtl/frame_byte_mux.sv
`default_nettype none
// ============================================================================
//  Module   : frame_byte_mux
//  Purpose  : Combinational selection of byte `sel` (0 = MSB byte) from the
//             assembled frame.
//  Ports    : frame    [FRAME_W-1:0] in  - assembled frame
//             sel      [SEL_W-1:0]   in  - byte index, 0 = most significant
//             byte_out [OUT_W-1:0]   out - selected byte
//  Revision : 1.0 - initial release
// ============================================================================
module frame_byte_mux
    import field_pack_pkg::*;
(
    input  logic [FRAME_W-1:0] frame,
    input  logic [SEL_W-1:0]   sel,
    output logic [OUT_W-1:0]   byte_out
);

    logic [OUT_W-1:0] bytes [NUM_OUT];

    generate
        for (genvar b = 0; b < NUM_OUT; b++) begin : g_byte
            assign bytes[b] = frame[byte_lsb(b) +: OUT_W];
        end
    endgenerate

    assign byte_out = bytes[sel];

endmodule : frame_byte_mux
`default_nettype wire

// File: rtl/field_pack_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : field_pack_sequencer
//  Purpose  : Collects NUM_FIELDS fields of FIELD_W bits over a valid/ready
//             handshake, packs them MSB-first with a constant pad into a
//             FRAME_W-bit frame, then emits the frame as NUM_OUT bytes,
//             MSB byte first, over a second valid/ready handshake.
//  Ports    : clk                 in  - rising-edge clock
//             reset               in  - asynchronous active-high reset
//             in_valid/in_data    in  - field producer
//             in_ready            out - field accepted when in_valid && in_ready
//             out_valid/out_data  out - registered output byte
//             out_ready           in  - byte accepted when out_valid && out_ready
//             abort               in  - synchronous discard of current frame
//             frame_done          out - one-cycle pulse after the last byte
//             field_cnt           out - fields collected in current frame
//  Revision : 1.0 - initial release
// ============================================================================
module field_pack_sequencer
    import field_pack_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [FIELD_W-1:0] in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [OUT_W-1:0]   out_data,
    input  logic               out_ready,
    input  logic               abort,
    output logic               frame_done,
    output logic [CNT_W-1:0]   field_cnt
);

    localparam logic [CNT_W-1:0] LAST_FIELD = CNT_W'(NUM_FIELDS - 1);
    localparam logic [SEL_W-1:0] LAST_BYTE  = SEL_W'(NUM_OUT - 1);

    state_t             state_q,      state_d;
    logic [FRAME_W-1:0] frame_q,      frame_d;
    logic [CNT_W-1:0]   field_cnt_q,  field_cnt_d;
    logic [SEL_W-1:0]   byte_cnt_q,   byte_cnt_d;
    logic               frame_done_q, frame_done_d;
    logic [OUT_W-1:0]   out_data_q,   out_data_d;
    logic [OUT_W-1:0]   next_byte;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= COLLECT;
            frame_q      <= '0;
            field_cnt_q  <= '0;
            byte_cnt_q   <= '0;
            frame_done_q <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            field_cnt_q  <= field_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            frame_done_q <= frame_done_d;
            out_data_q   <= out_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        field_cnt_d  = field_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        frame_done_d = 1'b0;

        if (abort) begin
            // Abort wins over any handshake this cycle; the frame register is
            // left as is because every field slot is rewritten next frame.
            state_d     = COLLECT;
            field_cnt_d = '0;
            byte_cnt_d  = '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (in_valid) begin
                        frame_d[field_lsb(field_cnt_q) +: FIELD_W] = in_data;
                        frame_d[PAD_W-1:0] = PAD_VALUE;
                        if (field_cnt_q == LAST_FIELD) begin
                            state_d     = EMIT;
                            field_cnt_d = '0;
                            byte_cnt_d  = '0;
                        end else begin
                            field_cnt_d = field_cnt_q + CNT_W'(1);
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (byte_cnt_q == LAST_BYTE) begin
                            state_d      = COLLECT;
                            byte_cnt_d   = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            byte_cnt_d = byte_cnt_q + SEL_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = COLLECT;
                end
            endcase
        end
    end

    // The output byte register is loaded with the byte the *next* state will
    // present, so the first byte appears one cycle after the last field and
    // the value holds naturally while the consumer stalls.
    frame_byte_mux u_byte_mux (
        .frame    (frame_d),
        .sel      (byte_cnt_d),
        .byte_out (next_byte)
    );

    always_comb begin
        out_data_d = '0;
        if (state_d == EMIT) begin
            out_data_d = next_byte;
        end
    end

    assign in_ready   = (state_q == COLLECT);
    assign out_valid  = (state_q == EMIT);
    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;
    assign field_cnt  = field_cnt_q;

endmodule : field_pack_sequencer
`default_nettype wire

// File: doc/field_pack_sequencer.md
Name: field_pack_sequencer

Overview:
Sequencer around the six-field / four-byte concatenation datapath. It accepts 5-bit fields one at a time over a valid/ready handshake and assembles six of them, plus a constant 2-bit pad, into a 32-bit frame. It then emits the frame as four 8-bit bytes, MSB byte first, over a second valid/ready handshake. It sits between a field producer and a byte-wide consumer.

Parameters:
FIELD_W, 5, width of each input field
NUM_FIELDS, 6, fields per frame
OUT_W, 8, width of each output byte
NUM_OUT, 4, bytes per frame
PAD_VALUE, 2'b11, constant appended at the LSB end; PAD_W = NUM_OUT*OUT_W - NUM_FIELDS*FIELD_W (= 2, must be >= 0)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  producer has a field
in_data  input  FIELD_W  field value
in_ready  output  1  block accepts a field this cycle
out_valid  output  1  out_data holds a valid byte
out_data  output  OUT_W  current byte
out_ready  input  1  consumer accepts the byte this cycle
abort  input  1  synchronous discard of the current frame
frame_done  output  1  one-cycle pulse after the last byte of a frame is accepted
field_cnt  output  3  number of fields collected in the current frame (status)

Behaviour:
- Reset (async, active-high) values: state=COLLECT, frame register=0, field_cnt=0, byte counter=0, in_ready=1, out_valid=0, out_data=0, frame_done=0.
- States: COLLECT and EMIT.
- COLLECT:
  - in_ready=1 and out_valid=0.
  - A field is accepted on a cycle with in_valid && in_ready.
  - The k-th accepted field (k=0..5) lands in frame bits [31-5k : 27-5k]; field 0 is the MSB field. Frame bits [1:0] = PAD_VALUE.
  - field_cnt increments on each accept.
  - On the 6th accept: next cycle state=EMIT, field_cnt returns to 0, byte counter=0.
- EMIT:
  - in_ready=0. in_valid is ignored and produces no change.
  - out_valid=1 from the first cycle after the 6th accept, so field-to-first-byte latency is 1 cycle.
  - out_data = frame[31-8b : 24-8b] for byte counter b=0..3.
  - out_data must hold stable while out_valid && !out_ready.
  - A byte transfers on out_valid && out_ready; the byte counter increments on each transfer.
  - On the 4th transfer: next cycle state=COLLECT, out_valid=0, in_ready=1, frame_done=1 for exactly that one cycle.
  - There is no overlap between frames; throughput is at least 10 cycles per frame.
- abort:
  - Sampled on the clock edge. It has priority over any in/out handshake in the same cycle; that field or byte is treated as not transferred.
  - Next cycle: state=COLLECT, field_cnt=0, byte counter=0, out_valid=0, frame_done=0.
  - The frame register is not required to clear.
  - abort while idle in COLLECT with field_cnt=0 has no effect.
- Reset mid-frame discards everything immediately; no frame_done is produced.
- Arithmetic: no addition on data; pure bit placement. Counters never exceed NUM_FIELDS-1 and NUM_OUT-1. The wrap is explicit via the state change, not via overflow.
- out_data is registered, not driven combinationally from out_ready.

Decomposition:
- Package field_pack_pkg holds: FIELD_W, NUM_FIELDS, OUT_W, NUM_OUT, PAD_W, PAD_VALUE, and a state enum {COLLECT, EMIT}.
- One sub-module is natural: frame_byte_mux, a combinational selection of byte b from the 32-bit frame. It keeps the bit-placement rule in one place, shared with the assembly logic.
- The top level holds the FSM, the counters and the handshakes.

Test Plan:
- Fields 0x00,0x01,0x03,0x07,0x0F,0x1F sent back-to-back with out_ready=1 -> bytes 0x00,0x46,0x77,0xFF on four consecutive cycles starting 1 cycle after the 6th accept; frame_done pulses once in the following cycle.
- All six fields 0x1F -> bytes 0xFF,0xFF,0xFF,0xFF; all six fields 0x00 -> bytes 0x00,0x00,0x00,0x03 (pad visible).
- out_ready held low for 5 cycles during byte 1 of the first frame -> out_data stays 0x46 with out_valid=1; in_ready stays 0 and in_valid pulses are ignored; the sequence resumes with 0x77 once out_ready is raised.
- abort asserted after 3 fields, then fields 0x1F x6 -> field_cnt drops to 0; output is 0xFF x4, so no stale fields appear.
- abort on the same cycle as the byte-2 handshake -> byte not counted; out_valid=0 next cycle; no frame_done.
- reset asserted asynchronously mid-EMIT (between clock edges) -> out_valid, frame_done and field_cnt go to 0 immediately; in_ready=1 after reset releases.
